// File: rtl/expr_eval_ctrl_pkg.sv
// Shared types and constants for the streaming expression evaluator.
// Character classes, FSM states, operator encoding and ASCII literals.
package expr_eval_ctrl_pkg;

  typedef enum logic [1:0] {
    TYPE_OTHER = 2'd0,
    TYPE_DIGIT = 2'd1,
    TYPE_OP    = 2'd2,
    TYPE_TERM  = 2'd3
  } char_type_e;

  typedef enum logic [1:0] {
    ST_EXP_NUM = 2'd0,
    ST_EXP_OP  = 2'd1,
    ST_ERR     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic {
    LAST_OP_PLUS = 1'b0,
    LAST_OP_MUL  = 1'b1
  } last_op_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_STAR = 8'h2A;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;

  function automatic logic is_digit_char(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/expr_eval_ctrl_char_class.sv
// Combinational ASCII classifier: character class, multiply flag and digit value.
module expr_eval_ctrl_char_class
  import expr_eval_ctrl_pkg::*;
(
  input  logic [7:0] ch,
  output char_type_e char_type,
  output logic       is_mul,
  output logic [3:0] digit
);

  // '0'..'9' occupy 0x30..0x39, so the low nibble is already the value
  always_comb begin
    char_type = TYPE_OTHER;
    is_mul    = 1'b0;
    digit     = 4'd0;
    if (is_digit_char(ch)) begin
      char_type = TYPE_DIGIT;
      digit     = ch[3:0];
    end else if ((ch == ASCII_PLUS) || (ch == ASCII_STAR)) begin
      char_type = TYPE_OP;
      is_mul    = (ch == ASCII_STAR);
    end else if (ch == ASCII_EQ) begin
      char_type = TYPE_TERM;
    end
  end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Grammar checker and evaluator for "digit (op digit)* =" with '*' binding tighter than '+'.
// Produces one result/error pair per expression over a valid/ready handshake.
module expr_eval_ctrl
  import expr_eval_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   char,
  input  logic         char_valid,
  output logic         char_ready,
  output logic [W-1:0] result,
  output logic         result_err,
  output logic         result_valid,
  input  logic         result_ready
);

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  last_op_e     last_op_q, last_op_d;
  logic [W-1:0] result_q, result_d;
  logic         result_err_q, result_err_d;
  logic         result_valid_q, result_valid_d;

  char_type_e   char_type;
  logic         is_mul;
  logic [3:0]   digit;
  logic [W-1:0] digit_ext;
  logic         char_accept;

  expr_eval_ctrl_char_class u_char_class (
    .ch        (char),
    .char_type (char_type),
    .is_mul    (is_mul),
    .digit     (digit)
  );

  assign digit_ext    = W'(digit);
  assign char_ready   = (state_q != ST_DONE);
  assign char_accept  = char_valid && char_ready;
  assign result       = result_q;
  assign result_err   = result_err_q;
  assign result_valid = result_valid_q;

  // sum holds the finished '+' terms; term holds the running product not yet added
  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    term_d         = term_q;
    last_op_d      = last_op_q;
    result_d       = result_q;
    result_err_d   = result_err_q;
    result_valid_d = result_valid_q;

    case (state_q)
      ST_EXP_NUM: begin
        if (char_accept) begin
          case (char_type)
            TYPE_DIGIT: begin
              state_d = ST_EXP_OP;
              if (last_op_q == LAST_OP_MUL) begin
                term_d = term_q * digit_ext;
              end else begin
                sum_d  = sum_q + term_q;
                term_d = digit_ext;
              end
            end
            TYPE_TERM: begin
              state_d        = ST_DONE;
              result_d       = '0;
              result_err_d   = 1'b1;
              result_valid_d = 1'b1;
            end
            default: state_d = ST_ERR;
          endcase
        end
      end

      ST_EXP_OP: begin
        if (char_accept) begin
          case (char_type)
            TYPE_OP: begin
              state_d   = ST_EXP_NUM;
              last_op_d = is_mul ? LAST_OP_MUL : LAST_OP_PLUS;
            end
            TYPE_TERM: begin
              state_d        = ST_DONE;
              result_d       = sum_q + term_q;
              result_err_d   = 1'b0;
              result_valid_d = 1'b1;
            end
            default: state_d = ST_ERR;
          endcase
        end
      end

      ST_ERR: begin
        if (char_accept && (char_type == TYPE_TERM)) begin
          state_d        = ST_DONE;
          result_d       = '0;
          result_err_d   = 1'b1;
          result_valid_d = 1'b1;
        end
      end

      // result/result_err are left untouched so the consumer can still read them
      ST_DONE: begin
        if (result_ready) begin
          state_d        = ST_EXP_NUM;
          sum_d          = '0;
          term_d         = '0;
          last_op_d      = LAST_OP_PLUS;
          result_valid_d = 1'b0;
        end
      end

      default: state_d = ST_EXP_NUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EXP_NUM;
      sum_q          <= '0;
      term_q         <= '0;
      last_op_q      <= LAST_OP_PLUS;
      result_q       <= '0;
      result_err_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      term_q         <= term_d;
      last_op_q      <= last_op_d;
      result_q       <= result_d;
      result_err_q   <= result_err_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Self-checking bench: W=16 and W=8 instances share one stimulus stream and are
// compared against a string-level expression evaluator.
module tb_expr_eval_ctrl;

  typedef byte bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        result_ready;

  logic        char_ready16, char_ready8;
  logic [15:0] result16;
  logic [7:0]  result8;
  logic        err16, err8, valid16, valid8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  expr_eval_ctrl #(.W(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .char         (char_in),
    .char_valid   (char_valid),
    .char_ready   (char_ready16),
    .result       (result16),
    .result_err   (err16),
    .result_valid (valid16),
    .result_ready (result_ready)
  );

  expr_eval_ctrl #(.W(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .char         (char_in),
    .char_valid   (char_valid),
    .char_ready   (char_ready8),
    .result       (result8),
    .result_err   (err8),
    .result_valid (valid8),
    .result_ready (result_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t str_to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Whole-string evaluation: validate the grammar, then sum of products, mod 2^32.
  function automatic void model_eval(input bq_t q, output bit err, output int unsigned val);
    int unsigned sum, prod, d;
    err = ((q.size() % 2) == 0);
    for (int i = 0; i < q.size(); i++) begin
      if ((i % 2) == 0) begin
        if (q[i] < 8'h30 || q[i] > 8'h39) err = 1'b1;
      end else if (q[i] != 8'h2B && q[i] != 8'h2A) begin
        err = 1'b1;
      end
    end
    val = 0;
    if (!err) begin
      sum  = 0;
      prod = {24'd0, q[0]} - 32'd48;
      for (int i = 1; i + 1 < q.size(); i += 2) begin
        d = {24'd0, q[i+1]} - 32'd48;
        if (q[i] == 8'h2B) begin
          sum  = sum + prod;
          prod = d;
        end else begin
          prod = prod * d;
        end
      end
      val = sum + prod;
    end
  endfunction

  // Presents one character (after optional idle gap) and holds it until accepted.
  task automatic send_char(input byte c, input int gap);
    int waited;
    char_valid = 1'b0;
    repeat (gap) step();
    char_in    = c;
    char_valid = 1'b1;
    waited     = 0;
    while (!char_ready16 && waited < 20) begin
      step();
      waited++;
    end
    total++;
    if (char_ready16 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL send_timeout: char_ready=%0b required 1", char_ready16);
    end
    step();
    char_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    char_in      = 8'h00;
    char_valid   = 1'b0;
    result_ready = 1'b1;
    #2;
    total++;
    if ({char_ready16, char_ready8, valid16, valid8, err16, err8} !== 6'b110000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got rdy=%0b/%0b vld=%0b/%0b err=%0b/%0b required rdy=1 vld=0 err=0",
               char_ready16, char_ready8, valid16, valid8, err16, err8);
    end
    total++;
    if (result16 !== 16'd0 || result8 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_result: got %0d/%0d required 0", result16, result8);
    end
    step();
    step();
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    string s;
    s = "1+2*3=";
    for (int i = 0; i < s.len(); i++) begin
      char_in    = s[i];
      char_valid = 1'b1;
      total++;
      if (char_ready16 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL basic_ready_%0d: got %0b required 1", i, char_ready16);
      end
      step();
    end
    char_in = 8'h35;
    total++;
    if ({valid16, valid8, err16, err8, char_ready16, result16, result8} !== {5'b11000, 16'd7, 8'd7}) begin
      bad++;
      $display("[TB] FAIL basic_result: got vld=%0b err=%0b rdy=%0b res=%0d/%0d required vld=1 err=0 rdy=0 res=7",
               valid16, err16, char_ready16, result16, result8);
    end
    step();
    total++;
    if ({char_ready16, valid16, valid8} !== 3'b100 || result16 !== 16'd7) begin
      bad++;
      $display("[TB] FAIL basic_after_hs: got rdy=%0b vld=%0b res=%0d required rdy=1 vld=0 res=7",
               char_ready16, valid16, result16);
    end
    step();
    char_valid = 1'b0;
    send_char(8'h3D, 0);
    total++;
    if ({valid16, err16, result16} !== {2'b10, 16'd5}) begin
      bad++;
      $display("[TB] FAIL basic_followon: got vld=%0b err=%0b res=%0d required vld=1 err=0 res=5",
               valid16, err16, result16);
    end
    step();
  endtask

  task automatic test_expressions();
    string exprs[8];
    bq_t q;
    bit exp_err;
    int unsigned exp_val;
    exprs = '{"9*9*9", "2*3+4*5", "12", "+3", "", "4+", "4a5", "5"};
    foreach (exprs[k]) begin
      q = str_to_q(exprs[k]);
      foreach (q[i]) send_char(q[i], 0);
      send_char(8'h3D, 0);
      model_eval(q, exp_err, exp_val);
      total++;
      if ({valid16, valid8, err16, err8, result16, result8} !==
          {2'b11, exp_err, exp_err, exp_val[15:0], exp_val[7:0]}) begin
        bad++;
        $display("[TB] FAIL expr_%0d: got vld=%0b/%0b err=%0b/%0b res=%0d/%0d required vld=1 err=%0b res=%0d/%0d",
                 k, valid16, valid8, err16, err8, result16, result8, exp_err, exp_val[15:0], exp_val[7:0]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    result_ready = 1'b0;
    send_char(8'h38, 0);
    send_char(8'h2B, 0);
    send_char(8'h31, 0);
    send_char(8'h3D, 0);
    char_in    = 8'h37;
    char_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({char_ready16, char_ready8, valid16, err16} !== 4'b0010 || result16 !== 16'd9) begin
        bad++;
        $display("[TB] FAIL hold_%0d: got rdy=%0b vld=%0b err=%0b res=%0d required rdy=0 vld=1 err=0 res=9",
                 c, char_ready16, valid16, err16, result16);
      end
      step();
    end
    result_ready = 1'b1;
    step();
    total++;
    if ({char_ready16, valid16} !== 2'b10 || result16 !== 16'd9) begin
      bad++;
      $display("[TB] FAIL release: got rdy=%0b vld=%0b res=%0d required rdy=1 vld=0 res=9",
               char_ready16, valid16, result16);
    end
    step();
    char_valid = 1'b0;
    send_char(8'h3D, 0);
    total++;
    if ({valid16, err16, result16} !== {2'b10, 16'd7}) begin
      bad++;
      $display("[TB] FAIL held_char: got vld=%0b err=%0b res=%0d required vld=1 err=0 res=7",
               valid16, err16, result16);
    end
    step();
  endtask

  task automatic test_async_reset();
    send_char(8'h33, 0);
    send_char(8'h2A, 0);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({char_ready16, valid16, valid8, err16} !== 4'b1000 || result16 !== 16'd0 || result8 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL async_abort: got rdy=%0b vld=%0b err=%0b res=%0d/%0d required rdy=1 vld=0 err=0 res=0",
               char_ready16, valid16, err16, result16, result8);
    end
    #1 rst_n = 1'b1;
    step();
    total++;
    if (valid16 !== 1'b0 || valid8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_no_result: got vld=%0b/%0b required 0", valid16, valid8);
    end
    send_char(8'h34, 0);
    send_char(8'h3D, 0);
    total++;
    if ({valid16, err16, result16, result8} !== {2'b10, 16'd4, 8'd4}) begin
      bad++;
      $display("[TB] FAIL async_next: got vld=%0b err=%0b res=%0d/%0d required vld=1 err=0 res=4",
               valid16, err16, result16, result8);
    end
    step();
  endtask

  task automatic test_gaps();
    string s;
    int gap;
    s = "2+3*4+1=";
    for (int i = 0; i < s.len(); i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        step();
        total++;
        if (char_ready16 !== 1'b1 || valid16 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL gap_%0d: got rdy=%0b vld=%0b required rdy=1 vld=0", i, char_ready16, valid16);
        end
      end
      send_char(s[i], 0);
    end
    total++;
    if ({valid16, err16, result16, result8} !== {2'b10, 16'd15, 8'd15}) begin
      bad++;
      $display("[TB] FAIL gaps_result: got vld=%0b err=%0b res=%0d/%0d required vld=1 err=0 res=15",
               valid16, err16, result16, result8);
    end
    step();
  endtask

  task automatic test_random();
    string pool;
    bq_t q;
    bit exp_err;
    int unsigned exp_val;
    int n, hold;
    pool = "0123456789+*a ";
    for (int e = 0; e < 40; e++) begin
      q.delete();
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(0, 4);
        q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        for (int k = 0; k < n; k++) begin
          q.push_back(($urandom_range(0, 1) == 1) ? 8'h2A : 8'h2B);
          q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
      end else begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      end
      result_ready = 1'b0;
      foreach (q[i]) send_char(q[i], $urandom_range(0, 2));
      send_char(8'h3D, $urandom_range(0, 2));
      model_eval(q, exp_err, exp_val);
      hold = $urandom_range(0, 3);
      repeat (hold) step();
      total++;
      if ({valid16, valid8, err16, err8, result16, result8} !==
          {2'b11, exp_err, exp_err, exp_val[15:0], exp_val[7:0]}) begin
        bad++;
        $display("[TB] FAIL rand_%0d: got vld=%0b/%0b err=%0b/%0b res=%0d/%0d required vld=1 err=%0b res=%0d/%0d",
                 e, valid16, valid8, err16, err8, result16, result8, exp_err, exp_val[15:0], exp_val[7:0]);
      end
      result_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_expressions();
    test_backpressure();
    test_async_reset();
    test_gaps();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
